gsim_sched: RTL and testbench

GSIM_SCHED -- requirements
Module: gsim_sched

---
 rtl/gsim_sched.sv | 157 +++++++++++++++
 tb/tb_gsim_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gsim_sched.sv
// -----------------------------------------------------------------------------
// gsim_sched -- command scheduler for a 16x16 Gauss-Seidel solver.
//
// For every sweep (N_ITER sweeps per solve) and every row, the scheduler
// first issues one MAC command per off-diagonal column. The first of these
// commands carries o_acc_clr. It then issues one UPD command that writes
// X[row] back. The datapath accepts each command with a ready/valid handshake.
//
// Parameters
//   N_ITER        sweeps per solve, 1..16
// Ports
//   i_clk         clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_module_en   solve request level, held by the host until o_done
//   o_busy        solve in progress (ACC or UPD)
//   o_done        solve finished, held until i_module_en falls
//   o_mac_valid   MAC command A[o_row][o_col]*X[o_col] is valid
//   i_mac_ready   datapath accepts the MAC command
//   o_acc_clr     with o_mac_valid: load the product instead of adding it
//   o_upd_valid   request update of X[o_row]
//   i_upd_ready   datapath accepts the update
//   o_row/o_col   current matrix indices
//   o_iter        current sweep index
// -----------------------------------------------------------------------------
module gsim_sched #(
   parameter int N_ITER = 16
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_module_en,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_mac_valid,
   input  logic       i_mac_ready,
   output logic       o_acc_clr,
   output logic       o_upd_valid,
   input  logic       i_upd_ready,
   output logic [3:0] o_row,
   output logic [3:0] o_col,
   output logic [3:0] o_iter
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      UPD  = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam logic [3:0] LAST_ITER = 4'(N_ITER - 1);

   state_t     state_q, state_d;
   logic [3:0] row_q, row_d;
   logic [3:0] col_q, col_d;
   logic [3:0] iter_q, iter_d;
   logic       done_q, done_d;

   logic [3:0] col_inc;
   logic [3:0] col_next;
   logic [3:0] first_col;
   logic       last_col;

   // Column walk skips the diagonal. Row 0 starts at column 1. Row 15 ends at
   // column 14.
   assign col_inc   = col_q + 4'd1;
   assign col_next  = (col_inc == row_q) ? (col_q + 4'd2) : col_inc;
   assign first_col = (row_q == 4'd0) ? 4'd1 : 4'd0;
   assign last_col  = (row_q == 4'd15) ? (col_q == 4'd14) : (col_q == 4'd15);

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      iter_d  = iter_q;
      done_d  = done_q;
      case (state_q)
         IDLE: begin
            if (i_module_en) begin
               state_d = ACC;
               row_d   = 4'd0;
               col_d   = 4'd1;
               iter_d  = 4'd0;
               done_d  = 1'b0;
            end
         end
         ACC: begin
            if (i_mac_ready) begin
               if (last_col) begin
                  // Column is held so the UPD command still names the row's
                  // final column.
                  state_d = UPD;
               end else begin
                  col_d = col_next;
               end
            end
         end
         UPD: begin
            if (i_upd_ready) begin
               if (row_q != 4'd15) begin
                  // Every row after row 0 begins at column 0.
                  row_d   = row_q + 4'd1;
                  col_d   = 4'd0;
                  state_d = ACC;
               end else if (iter_q != LAST_ITER) begin
                  iter_d  = iter_q + 4'd1;
                  row_d   = 4'd0;
                  col_d   = 4'd1;
                  state_d = ACC;
               end else begin
                  state_d = HOLD;
                  done_d  = 1'b1;
               end
            end
         end
         HOLD: begin
            // A request that dropped mid-solve releases HOLD on the first
            // cycle.
            if (!i_module_en) begin
               state_d = IDLE;
               done_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         row_q   <= 4'd0;
         col_q   <= 4'd0;
         iter_q  <= 4'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         iter_q  <= iter_d;
         done_q  <= done_d;
      end
   end

   // All outputs come straight from registered state. They cannot change
   // while a command is stalled.
   assign o_busy      = (state_q == ACC) || (state_q == UPD);
   assign o_done      = done_q;
   assign o_mac_valid = (state_q == ACC);
   assign o_acc_clr   = (state_q == ACC) && (col_q == first_col);
   assign o_upd_valid = (state_q == UPD);
   assign o_row       = row_q;
   assign o_col       = col_q;
   assign o_iter      = iter_q;

endmodule

// File: tb/tb_gsim_sched.sv
// -----------------------------------------------------------------------------
// tb_gsim_sched -- self-checking bench for gsim_sched.
//
// The bench uses three instances: N_ITER=16, N_ITER=2 and N_ITER=1. Before
// each solve it builds the full expected command stream as a queue, in nested
// sweep/row/column order. Each offered command is compared with the head of
// that queue, and the head is popped when the handshake completes.
// -----------------------------------------------------------------------------
module tb_gsim_sched;

   logic       clk;
   logic       rst;
   logic       en   [3];
   logic       mrdy [3];
   logic       urdy [3];
   logic       busy [3];
   logic       done [3];
   logic       mv   [3];
   logic       clr  [3];
   logic       uv   [3];
   logic [3:0] row_o[3];
   logic [3:0] col_o[3];
   logic [3:0] it_o [3];

   int n_vec;
   int n_err;

   // {upd, mac, clr, iter, row, col}
   logic [14:0] exp_q[$];

   gsim_sched #(.N_ITER(16)) u_dut16 (
      .i_clk(clk), .i_reset(rst), .i_module_en(en[0]),
      .o_busy(busy[0]), .o_done(done[0]), .o_mac_valid(mv[0]),
      .i_mac_ready(mrdy[0]), .o_acc_clr(clr[0]), .o_upd_valid(uv[0]),
      .i_upd_ready(urdy[0]), .o_row(row_o[0]), .o_col(col_o[0]), .o_iter(it_o[0]));

   gsim_sched #(.N_ITER(2)) u_dut2 (
      .i_clk(clk), .i_reset(rst), .i_module_en(en[1]),
      .o_busy(busy[1]), .o_done(done[1]), .o_mac_valid(mv[1]),
      .i_mac_ready(mrdy[1]), .o_acc_clr(clr[1]), .o_upd_valid(uv[1]),
      .i_upd_ready(urdy[1]), .o_row(row_o[1]), .o_col(col_o[1]), .o_iter(it_o[1]));

   gsim_sched #(.N_ITER(1)) u_dut1 (
      .i_clk(clk), .i_reset(rst), .i_module_en(en[2]),
      .o_busy(busy[2]), .o_done(done[2]), .o_mac_valid(mv[2]),
      .i_mac_ready(mrdy[2]), .o_acc_clr(clr[2]), .o_upd_valid(uv[2]),
      .i_upd_ready(urdy[2]), .o_row(row_o[2]), .o_col(col_o[2]), .o_iter(it_o[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] obs_tup(input int k);
      return {uv[k], mv[k], clr[k], it_o[k], row_o[k], col_o[k]};
   endfunction

   // Expected command stream for one solve: for every sweep and every row,
   // each off-diagonal column in ascending order, then one update.
   task automatic build_q(input int n);
      bit first;
      int lc;
      exp_q.delete();
      for (int it = 0; it < n; it++) begin
         for (int r = 0; r < 16; r++) begin
            first = 1'b1;
            lc    = 0;
            for (int c = 0; c < 16; c++) begin
               if (c != r) begin
                  exp_q.push_back({1'b0, 1'b1, first, 4'(it), 4'(r), 4'(c)});
                  first = 1'b0;
                  lc    = c;
               end
            end
            exp_q.push_back({1'b1, 1'b0, 1'b0, 4'(it), 4'(r), 4'(lc)});
         end
      end
   endtask

   // Run one complete solve on instance k. The task is entered between edges
   // with the instance idle. bp selects random backpressure, and drop_at
   // (if >= 0) drops i_module_en after that many edges.
   task automatic run_solve(input int k, input int n, input bit bp, input int drop_at);
      int          edges;
      int          mac_cnt;
      int          upd_cnt;
      int          clr_cnt;
      bit          prev_stall;
      bit          xfer;
      logic [14:0] tup;
      logic [14:0] prev_tup;
      build_q(n);
      edges = 0; mac_cnt = 0; upd_cnt = 0; clr_cnt = 0;
      prev_stall = 1'b0; prev_tup = '0;
      en[k] = 1'b1; mrdy[k] = 1'b1; urdy[k] = 1'b1;
      @(posedge clk); #1;            // start edge
      while (exp_q.size() > 0 && edges < 20 * n * 256) begin
         if (bp) begin
            mrdy[k] = ($urandom_range(0, 3) != 0);
            urdy[k] = ($urandom_range(0, 2) != 0);
         end
         if (edges == drop_at) en[k] = 1'b0;
         #1;
         tup = obs_tup(k);
         chk("valid_exclusive", 32'(mv[k] & uv[k]), 32'd0);
         chk("busy_tracks_valid", 32'(busy[k]), 32'(mv[k] | uv[k]));
         chk("done_low_in_solve", 32'(done[k]), 32'd0);
         if (mv[k]) chk("col_not_diag", 32'(col_o[k] != row_o[k]), 32'd1);
         if (prev_stall) chk("stall_stable", 32'(tup), 32'(prev_tup));
         chk("cmd", 32'(tup), 32'(exp_q[0]));
         xfer = (mv[k] && mrdy[k]) || (uv[k] && urdy[k]);
         if (xfer) begin
            if (mv[k]) mac_cnt++;
            if (mv[k] && clr[k]) clr_cnt++;
            if (uv[k]) upd_cnt++;
            void'(exp_q.pop_front());
         end
         prev_stall = (mv[k] || uv[k]) && !xfer;
         prev_tup   = tup;
         @(posedge clk); #1;
         edges++;
      end
      chk("solve_timeout", 32'(exp_q.size()), 32'd0);
      chk("mac_count", 32'(mac_cnt), 32'(240 * n));
      chk("upd_count", 32'(upd_cnt), 32'(16 * n));
      chk("clr_count", 32'(clr_cnt), 32'(16 * n));
      if (!bp) chk("done_latency", 32'(edges), 32'(256 * n));
      chk("done_set", 32'(done[k]), 32'd1);
      chk("busy_after_done", 32'(busy[k]), 32'd0);
      mrdy[k] = 1'b1; urdy[k] = 1'b1;
   endtask

   initial begin
      bit found;
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         en[k] = 1'b0; mrdy[k] = 1'b1; urdy[k] = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      chk("rst_busy", 32'(busy[0]), 32'd0);
      chk("rst_done", 32'(done[0]), 32'd0);
      chk("rst_mac_valid", 32'(mv[0]), 32'd0);
      chk("rst_acc_clr", 32'(clr[0]), 32'd0);
      chk("rst_upd_valid", 32'(uv[0]), 32'd0);
      chk("rst_row_col_iter", 32'({row_o[0], col_o[0], it_o[0]}), 32'd0);
      rst = 1'b0;

      // With no request, the instance stays idle.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("idle_no_start", 32'(busy[0] | mv[0]), 32'd0);
      end

      // Full N_ITER=16 solve, always ready
      run_solve(0, 16, 1'b0, -1);

      // The request is held after done, then dropped.
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("hold_done", 32'(done[0]), 32'd1);
         chk("hold_not_busy", 32'(busy[0]), 32'd0);
      end
      en[0] = 1'b0;
      #1;
      chk("done_before_drop_edge", 32'(done[0]), 32'd1);
      @(posedge clk); #1;
      chk("done_cleared_on_drop", 32'(done[0]), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("no_restart", 32'(busy[0] | mv[0] | done[0]), 32'd0);
      end

      // Reset pulse mid-solve at iter=3, row=7
      en[0] = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 5000 && !found; i++) begin
         @(posedge clk); #1;
         if (it_o[0] == 4'd3 && row_o[0] == 4'd7) found = 1'b1;
      end
      chk("reached_iter3_row7", 32'(found), 32'd1);
      #2;
      rst   = 1'b1;
      en[0] = 1'b0;
      #1;
      chk("async_rst_busy", 32'(busy[0]), 32'd0);
      chk("async_rst_valids", 32'({mv[0], uv[0], clr[0], done[0]}), 32'd0);
      chk("async_rst_indices", 32'({row_o[0], col_o[0], it_o[0]}), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("no_resume_after_rst", 32'(busy[0]), 32'd0);
      end
      run_solve(0, 16, 1'b0, -1);
      en[0] = 1'b0;
      @(posedge clk); #1;

      // N_ITER=2 with random backpressure
      run_solve(1, 2, 1'b1, -1);
      en[1] = 1'b0;
      @(posedge clk); #1;
      chk("bp_done_cleared", 32'(done[1]), 32'd0);

      // N_ITER=1 with the request dropped mid-solve
      run_solve(2, 1, 1'b0, 100);
      @(posedge clk); #1;
      chk("drop_done_one_cycle", 32'(done[2]), 32'd0);
      chk("drop_back_idle", 32'(busy[2] | mv[2]), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
